// File: rtl/axi4_lite_master_read_seq.sv
// axi4_lite_master_read_seq: multi-beat AXI4-Lite read master with outstanding-read credit.
// Define AXIL_RD_TIMEOUT_EN to add the response watchdog.
module axi4_lite_master_read_seq #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 8,
   parameter int MAX_OUTST   = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              USR_ENA,
   input  logic [ADDR_W-1:0] USR_ADDR,
   input  logic [LEN_W-1:0]  USR_LEN,
   output logic              USR_BUSY,
   output logic              USR_DONE,
   output logic              USR_ERR,
   output logic [DATA_W-1:0] USR_RDATA,
   output logic              USR_RVALID,
   input  logic              USR_RREADY,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [2:0]        ARPROT,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RVALID,
   output logic              RREADY
);
   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int CW = LEN_W + 1;
   localparam logic [OW-1:0] MAXO = OW'(MAX_OUTST);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q;
   logic [ADDR_W-1:0] araddr_q;
   logic arvalid_q, err_q, ar_hs, r_hs, arvalid_d, timeout, unused_resp;
   logic [CW-1:0] ar_left_q, r_left_q, ar_left_d;
   logic [OW-1:0] outst_q, outst_d;
   logic eligible;
   assign eligible    = state_q == RUN && outst_q != '0;
   assign RREADY      = USR_RREADY && eligible;
   assign USR_RVALID  = RVALID && eligible;
   assign USR_RDATA   = RDATA;
   assign USR_BUSY    = state_q != IDLE;
   assign USR_DONE    = state_q == DONE;
   assign USR_ERR     = err_q;
   assign ARADDR      = araddr_q;
   assign ARVALID     = arvalid_q;
   assign ARPROT      = 3'b000;
   assign unused_resp = RRESP[0];
   assign ar_hs       = arvalid_q && ARREADY;
   assign r_hs        = RVALID && RREADY;
   assign ar_left_d   = ar_left_q - CW'(ar_hs);
   assign outst_d     = outst_q + OW'(ar_hs) - OW'(r_hs);
   // a pending AR holds; a new one needs beats left and credit after this cycle's handshakes
   assign arvalid_d   = (arvalid_q && !ARREADY) || (ar_left_d != '0 && outst_d < MAXO);
`ifdef AXIL_RD_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYC + 1);
   logic [WW-1:0] wd_q;
   logic waiting;
   assign waiting = state_q == RUN && !arvalid_q && outst_q != '0 && !r_hs;
   assign timeout = waiting && wd_q == WW'(TIMEOUT_CYC - 1);
   always_ff @(posedge ACLK) wd_q <= (ARESET || !waiting || timeout) ? '0 : wd_q + WW'(1);
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         ar_left_q <= '0;
         r_left_q  <= '0;
         outst_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (USR_ENA) begin
               state_q   <= RUN;
               araddr_q  <= USR_ADDR;
               arvalid_q <= 1'b1;
               ar_left_q <= CW'(USR_LEN) + CW'(1);
               r_left_q  <= CW'(USR_LEN) + CW'(1);
               outst_q   <= '0;
               err_q     <= 1'b0;
            end
            RUN: begin
               ar_left_q <= ar_left_d;
               outst_q   <= outst_d;
               arvalid_q <= arvalid_d;
               if (ar_hs) araddr_q <= araddr_q + STRIDE;
               if (r_hs) r_left_q <= r_left_q - CW'(1);
               if ((r_hs && RRESP[1]) || timeout) err_q <= 1'b1;
               if (timeout || (r_hs && r_left_q == CW'(1))) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_lite_master_read_seq.sv
// tb_axi4_lite_master_read_seq: directed bench for the AXI4-Lite read master (MAX_OUTST 4 and 1).
module tb_axi4_lite_master_read_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, ena, sel, usr_rready, arready, rvalid;
   logic [31:0] usr_addr, rdata;
   logic [7:0] usr_len;
   logic [1:0] rresp;
   logic busy[2], done[2], err[2], urv[2], arv[2], rrdy[2];
   logic [31:0] urd[2], ara[2];
   logic [2:0] prot[2];
   logic busy_m, done_m, err_m, urv_m, arv_m, rrdy_m;
   logic [31:0] urd_m, ara_m;
   assign busy_m = busy[sel];
   assign done_m = done[sel];
   assign err_m  = err[sel];
   assign urv_m  = urv[sel];
   assign arv_m  = arv[sel];
   assign rrdy_m = rrdy[sel];
   assign urd_m  = urd[sel];
   assign ara_m  = ara[sel];
   axi4_lite_master_read_seq #(.MAX_OUTST(4), .TIMEOUT_CYC(16)) u4 (
      .ACLK(clk), .ARESET(rst), .USR_ENA(ena && !sel), .USR_ADDR(usr_addr), .USR_LEN(usr_len),
      .USR_BUSY(busy[0]), .USR_DONE(done[0]), .USR_ERR(err[0]), .USR_RDATA(urd[0]),
      .USR_RVALID(urv[0]), .USR_RREADY(usr_rready), .ARADDR(ara[0]), .ARPROT(prot[0]),
      .ARVALID(arv[0]), .ARREADY(arready), .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid),
      .RREADY(rrdy[0]));
   axi4_lite_master_read_seq #(.MAX_OUTST(1), .TIMEOUT_CYC(16)) u1 (
      .ACLK(clk), .ARESET(rst), .USR_ENA(ena && sel), .USR_ADDR(usr_addr), .USR_LEN(usr_len),
      .USR_BUSY(busy[1]), .USR_DONE(done[1]), .USR_ERR(err[1]), .USR_RDATA(urd[1]),
      .USR_RVALID(urv[1]), .USR_RREADY(usr_rready), .ARADDR(ara[1]), .ARPROT(prot[1]),
      .ARVALID(arv[1]), .ARREADY(arready), .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid),
      .RREADY(rrdy[1]));
   typedef struct {logic [31:0] a; int due;} rd_t;
   rd_t q[$];
   int cyc = 0, lat = 0, maxq = 0, checks = 0, errors = 0;
   logic [31:0] err_addr = 32'h1;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drive_slave();
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
      if (q.size() > 0) begin
         rvalid = q[0].due <= cyc;
         rdata  = mem(q[0].a);
         rresp  = q[0].a == err_addr ? 2'b10 : 2'b00;
      end
   endtask
   // handshakes are sampled just before the edge the DUT captures them on
   task automatic step();
      bit har, hr;
      logic [31:0] aa;
      #1;
      har = arv_m && arready;
      hr  = rvalid && rrdy_m;
      aa  = ara_m;
      @(posedge clk);
      #1;
      cyc++;
      if (hr && q.size() > 0) void'(q.pop_front());
      if (har) q.push_back('{a: aa, due: cyc + lat});
      if (rst) q.delete();
      if (q.size() > maxq) maxq = q.size();
      drive_slave();
   endtask
   task automatic run_cmd(input string tag, input logic [31:0] a, input logic [7:0] len, input int l,
                          input bit bp, input bit stall, input int exp_maxq, input int exp_k, input bit exp_err);
      logic [31:0] ea, er;
      int beats, dones, k;
      bit pend;
      lat = l; ea = a; er = a; beats = 0; dones = 0; maxq = 0; k = 0;
      usr_addr = a; usr_len = len; usr_rready = 1'b1; arready = 1'b1; ena = 1'b1;
      step();
      ena = 1'b0;
      check({tag, "_start_busy"}, 32'(busy_m), 1);
      check({tag, "_start_arvalid"}, 32'(arv_m), 1);
      check({tag, "_start_err"}, 32'(err_m), 0);
      while (k < 300 && !(dones > 0 && !busy_m)) begin
         usr_rready = !(bp && k >= 2 && k < 7);
         arready    = !(stall && k % 3 == 1);
         ena        = bp && k == 4;
         if (ena) usr_addr = 32'hDEAD_0000;
         #1;
         if (!usr_rready) check({tag, "_rready_bp"}, 32'(rrdy_m), 0);
         if (arv_m) check({tag, "_araddr"}, ara_m, ea);
         if (arv_m && arready) ea += 32'd4;
         if (rvalid && rrdy_m) begin
            check({tag, "_rdata"}, urd_m, mem(er));
            check({tag, "_urvalid"}, 32'(urv_m), 1);
            er += 32'd4;
            beats++;
         end
         pend = arv_m && !arready;
         step();
         k++;
         if (pend) check({tag, "_ar_hold"}, 32'(arv_m), 1);
         if (done_m) dones++;
      end
      ena = 1'b0;
      check({tag, "_beats"}, beats, 32'(len) + 1);
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_err"}, 32'(err_m), 32'(exp_err));
      check({tag, "_idle"}, 32'(busy_m), 0);
      if (exp_maxq >= 0) check({tag, "_max_outst"}, maxq, exp_maxq);
      if (exp_k >= 0) check({tag, "_cycles"}, k, exp_k);
   endtask
   initial begin
      int dones, done_k;
      rst = 1'b1; ena = 1'b0; sel = 1'b0; usr_rready = 1'b1; arready = 1'b1;
      usr_addr = '0; usr_len = '0;
      drive_slave();
      step();
      step();
      for (int i = 0; i < 2; i++) begin
         check("rst_busy", 32'(busy[i]), 0);
         check("rst_done", 32'(done[i]), 0);
         check("rst_err", 32'(err[i]), 0);
         check("rst_arvalid", 32'(arv[i]), 0);
         check("rst_araddr", ara[i], 0);
         check("rst_rready", 32'(rrdy[i]), 0);
         check("rst_arprot", 32'(prot[i]), 0);
      end
      rst = 1'b0;
      step();
      run_cmd("seq4", 32'h0000_1000, 8'd3, 0, 1'b0, 1'b0, 1, 6, 1'b0);
      sel = 1'b1;
      step();
      run_cmd("one_outst", 32'h0000_2000, 8'd2, 3, 1'b0, 1'b0, 1, 16, 1'b0);
      sel = 1'b0;
      step();
      run_cmd("credit", 32'h0000_3000, 8'd7, 5, 1'b0, 1'b0, 4, -1, 1'b0);
      err_addr = 32'h0;
      run_cmd("wrap_err", 32'hFFFF_FFFC, 8'd1, 0, 1'b0, 1'b0, -1, -1, 1'b1);
      check("err_sticky_idle", 32'(err_m), 1);
      err_addr = 32'h1;
      run_cmd("bp_stall", 32'h0000_4000, 8'd7, 1, 1'b1, 1'b1, -1, -1, 1'b0);
      lat = 1000; usr_addr = 32'h6000; usr_len = 8'd3; ena = 1'b1;
      step();
      ena = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("midrst_arvalid", 32'(arv_m), 0);
      check("midrst_araddr", ara_m, 0);
      check("midrst_rready", 32'(rrdy_m), 0);
      check("midrst_busy", 32'(busy_m), 0);
      check("midrst_done", 32'(done_m), 0);
      check("midrst_urvalid", 32'(urv_m), 0);
      rst = 1'b0;
      step();
      lat = 100000; usr_addr = 32'h5000; usr_len = 8'd0; ena = 1'b1;
      step();
      ena = 1'b0;
      dones = 0; done_k = -1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (done_m) begin
            dones++;
            done_k = k;
         end
      end
`ifdef AXIL_RD_TIMEOUT_EN
      check("to_done_pulses", dones, 1);
      check("to_done_cycle", done_k, 17);
      check("to_err", 32'(err_m), 1);
      check("to_idle", 32'(busy_m), 0);
`else
      check("wait_done_pulses", dones, 0);
      check("wait_busy", 32'(busy_m), 1);
      check("wait_err", 32'(err_m), 0);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("final_idle", 32'(busy_m), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi4_lite_master_read_seq.md
# axi4_lite_master_read_seq

Parametrised AXI4-Lite read master that executes a multi-beat sequential read command from a user-side start pulse. Generalises the single-transaction read state machine: configurable address/data width, a beat count per command, up to `MAX_OUTST` reads in flight, incrementing addresses, response-error capture and an optional response watchdog. Sits between a user control block and an AXI4-Lite interconnect slave port.

## Interface

Parameters:
- `ADDR_W`, 32: ARADDR and USR_ADDR width.
- `DATA_W`, 32: RDATA width; must be 32 or 64; address stride = `DATA_W/8`.
- `LEN_W`, 8: USR_LEN width; beats per command = USR_LEN+1.
- `MAX_OUTST`, 4: max AR accepted but R not yet accepted; ≥1. `MAX_OUTST`=1 gives one-at-a-time behaviour.
- `TIMEOUT_CYC`, 256: watchdog limit; used only with `AXIL_RD_TIMEOUT_EN`.

Ports:
- `ACLK`  in  1  clock; all logic on rising edge.
- `ARESET`  in  1  reset; synchronous, active-high.
- `USR_ENA`  in  1  command start; sampled only when USR_BUSY=0.
- `USR_ADDR`  in  ADDR_W  start address; must be `DATA_W/8`-aligned.
- `USR_LEN`  in  LEN_W  beat count minus one.
- `USR_BUSY`  out  1  command in progress (RUN or DONE).
- `USR_DONE`  out  1  one-cycle pulse at command end.
- `USR_ERR`  out  1  sticky: any RRESP≠OKAY or timeout; cleared on next accepted start.
- `USR_RDATA`  out  DATA_W  read data (= RDATA).
- `USR_RVALID`  out  1  = RVALID && RREADY-eligible.
- `USR_RREADY`  in  1  user accepts data.
- `ARADDR`  out  ADDR_W  read address, registered.
- `ARPROT`  out  3  constant 3'b000.
- `ARVALID`  out  1  registered.
- `ARREADY`  in  1.
- `RDATA`  in  DATA_W; `RRESP`  in  2; `RVALID`  in  1.
- `RREADY`  out  1  = USR_RREADY && state==RUN && outst>0.

## Operation

- FSM states IDLE, RUN, DONE. Reset → IDLE; all outputs 0, all counters 0, USR_ERR 0.
- IDLE: USR_ENA=1 → latch ARADDR=USR_ADDR, ar_left=r_left=USR_LEN+1, outst=0, clear USR_ERR, go RUN.
- RUN, AR side: ARVALID set when ar_left>0 and outst (including the AR being issued) <MAX_OUTST. Once high, ARVALID and ARADDR hold until ARREADY. On AR handshake: ar_left−1, outst+1, ARADDR += DATA_W/8 (modulo 2^ADDR_W, wraps silently). Back-to-back AR every cycle allowed while ARREADY=1 and credit remains.
- RUN, R side: on R handshake (RVALID&&RREADY): r_left−1, outst−1; RRESP[1]=1 → USR_ERR=1. Data is never buffered; USR_RREADY backpressure goes straight to RREADY.
- Simultaneous AR and R handshake: outst unchanged, both counters decrement.
- Last R handshake (r_left 1→0) → DONE. DONE: USR_DONE=1 for exactly one cycle, USR_BUSY=1, then IDLE.
- USR_ENA while busy: ignored, no queuing.
- RVALID while outst=0: RREADY stays 0; protocol violation, not recovered.
- ARESET mid-command: immediate return to IDLE next edge, ARVALID/RREADY drop; in-flight transactions abandoned (slave shares reset).

## Timing

- USR_ENA sampled at edge 0 → USR_BUSY=1 and ARVALID=1 visible after edge 0 (cycle 1).
- First ARADDR=USR_ADDR; minimum command latency with zero-wait slave and USR_RREADY=1: RVALID same cycle as acceptance → USR_DONE after edge of last R handshake, one cycle later back to IDLE.
- Steady-state throughput: 1 beat/cycle when MAX_OUTST≥2 and slave latency ≤ MAX_OUTST−1.
- USR_RDATA/USR_RVALID combinational from RDATA/RVALID; no added latency.

## Configuration

- `AXIL_RD_TIMEOUT_EN` defined: watchdog counter counts cycles in RUN with ARVALID=0, outst>0 and no R handshake; cleared by any R handshake. Reaching TIMEOUT_CYC → USR_ERR=1, RREADY=0, go DONE (USR_DONE pulse), outstanding responses discarded.
- Undefined: no counter; RUN waits indefinitely for responses. Ports identical in both builds.

## Test plan

- ADDR_W=32, USR_ADDR=0x1000, USR_LEN=3, zero-wait slave, MAX_OUTST=4 → ARADDR 0x1000,0x1004,0x1008,0x100C on 4 consecutive cycles; 4 USR_RVALID beats; one USR_DONE; USR_ERR=0.
- MAX_OUTST=1, slave R latency 3 cycles, USR_LEN=2 → never >1 outstanding; next ARVALID only after previous R handshake.
- USR_ADDR=0xFFFFFFFC, USR_LEN=1 → second ARADDR=0x00000000; RRESP=2'b10 on beat 2 → USR_ERR=1 after DONE, cleared on next USR_ENA.
- USR_RREADY low 5 cycles mid-command → RREADY=0, no beat lost; USR_ENA pulse while busy ignored; ARESET asserted mid-command → all outputs 0 next cycle.
- With `AXIL_RD_TIMEOUT_EN`, TIMEOUT_CYC=16, slave never responds → USR_DONE and USR_ERR=1 after 16 idle cycles; without macro → USR_BUSY stays 1.
